// File: rtl/ram4_bank_if.sv
// Bus bundle for ram4_bank: write/read port, clear request, status and debug strobes.
interface ram4_bank_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] in;
  logic             load;
  logic [1:0]       address;
  logic             clr_req;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic [3:0]       ld_vec;

  modport master (output in, load, address, clr_req, input out, busy, ld_vec);
  modport slave  (input in, load, address, clr_req, output out, busy, ld_vec);
endinterface

// File: rtl/ram4_bank.sv
// Four-word register bank with registered read and a one-word-per-cycle clear sequencer.
// Optional macro RAM4_BYPASS_EN makes same-address read-during-write return the new data.
module dmux4way (
  input  logic       in,
  input  logic [1:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d
);
  assign a = in & (sel == 2'd0);
  assign b = in & (sel == 2'd1);
  assign c = in & (sel == 2'd2);
  assign d = in & (sel == 2'd3);
endmodule

module ram4_bank #(parameter int WIDTH = 16) (
  input logic        clk,
  input logic        rst_n,
  ram4_bank_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                  state_q;
  logic [1:0]              clr_ptr_q;
  logic [3:0][WIDTH-1:0]   word_q;
  logic [WIDTH-1:0]        out_q, out_d;
  logic                    eff_load;
  logic [3:0]              ld_vec;

  // A pending or running clear masks every write strobe.
  assign eff_load = bus.load & (state_q == IDLE) & ~bus.clr_req;

  dmux4way u_dec (
    .in (eff_load),
    .sel(bus.address),
    .a  (ld_vec[0]),
    .b  (ld_vec[1]),
    .c  (ld_vec[2]),
    .d  (ld_vec[3])
  );

  always_comb begin
    out_d = word_q[bus.address];
`ifdef RAM4_BYPASS_EN
    if (ld_vec[bus.address]) out_d = bus.in;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_ptr_q <= 2'd0;
      word_q    <= '0;
      out_q     <= '0;
    end else begin
      out_q <= out_d;
      for (int i = 0; i < 4; i++)
        if (ld_vec[i]) word_q[i] <= bus.in;
      case (state_q)
        IDLE: if (bus.clr_req) begin
          state_q   <= CLEAR;
          clr_ptr_q <= 2'd0;
        end
        CLEAR: begin
          word_q[clr_ptr_q] <= '0;
          clr_ptr_q         <= clr_ptr_q + 2'd1;
          if (clr_ptr_q == 2'd3) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out    = out_q;
  assign bus.busy   = (state_q == CLEAR);
  assign bus.ld_vec = ld_vec;
endmodule

// File: tb/tb_ram4_bank.sv
// Directed + randomized bench for ram4_bank against a word-array reference model.
module tb_ram4_bank;
  localparam int WIDTH = 16;
`ifdef RAM4_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram4_bank_if #(.WIDTH(WIDTH)) bus ();
  ram4_bank #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: stored words, words still to clear, expected read register.
  logic [WIDTH-1:0] mem [4];
  int               clr_left;
  logic [WIDTH-1:0] out_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ldv_exp();
    if (bus.load && clr_left == 0 && !bus.clr_req) return 4'b0001 << bus.address;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mem[i] = '0;
    clr_left = 0;
    out_exp  = '0;
  endtask

  // Applies the sampled inputs for one rising edge.
  task automatic model_step();
    logic acc;
    acc = bus.load && clr_left == 0 && !bus.clr_req;
    out_exp = (BYP && acc) ? bus.in : mem[bus.address];
    if (clr_left > 0) begin
      mem[4 - clr_left] = '0;
      clr_left--;
    end else if (bus.clr_req) begin
      clr_left = 4;
    end else if (acc) begin
      mem[bus.address] = bus.in;
    end
  endtask

  task automatic cyc(input string tag);
    #1 chk({tag, ".ld_vec"}, {28'd0, bus.ld_vec}, {28'd0, ldv_exp()});
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".out"},  {16'd0, bus.out}, {16'd0, out_exp});
    chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, clr_left > 0});
  endtask

  task automatic drive(input logic ld, input logic [1:0] a, input logic [WIDTH-1:0] d, input logic cr);
    bus.load = ld; bus.address = a; bus.in = d; bus.clr_req = cr;
  endtask

  initial begin
    logic [WIDTH-1:0] pat [4];
    int busy_cycles;
    pat[0] = 16'h1111; pat[1] = 16'h2222; pat[2] = 16'h3333; pat[3] = 16'h4444;
    model_reset();
    drive(1'b0, 2'd0, '0, 1'b0);

    // 1. reset
    #3 rst_n = 1'b0;
    #1;
    chk("rst.out",    {16'd0, bus.out}, 32'd0);
    chk("rst.busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst.ld_vec", {28'd0, bus.ld_vec}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'(i), '0, 1'b0); cyc("rd0");
    end

    // 2. write four words then read back
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), pat[i], 1'b0);
      #1 chk("wr.ld_vec_onehot", {28'd0, bus.ld_vec}, 32'd1 << i);
      cyc("wr");
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'(i), '0, 1'b0); cyc("rdback");
    end

    // 3. read during write, same address
    drive(1'b1, 2'd2, 16'hBEEF, 1'b0); cyc("rdw");
    chk("rdw.value", {16'd0, bus.out}, BYP ? 32'hBEEF : 32'h3333);
    drive(1'b0, 2'd2, '0, 1'b0); cyc("rdw.after");

    // 4. clear beats a simultaneous write; busy lasts exactly four cycles
    drive(1'b1, 2'd1, 16'hAAAA, 1'b1);
    #1 chk("clr.ld_vec_zero", {28'd0, bus.ld_vec}, 32'd0);
    cyc("clr.start");
    drive(1'b0, 2'd1, '0, 1'b0);
    busy_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy) busy_cycles++;
      drive(1'b0, 2'(i), '0, 1'b0); cyc("clr.run");
    end
    chk("clr.busy_len", busy_cycles, 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'(i), '0, 1'b0); cyc("clr.rd");
      chk("clr.zero", {16'd0, bus.out}, 32'd0);
    end

    // 5. load and second clr_req while busy are ignored
    drive(1'b1, 2'd3, 16'h7777, 1'b0); cyc("pre5");
    drive(1'b0, 2'd3, '0, 1'b1); cyc("c5.start");
    drive(1'b1, 2'd3, 16'h5555, 1'b0); cyc("c5.load");
    drive(1'b1, 2'd3, 16'h5555, 1'b1); cyc("c5.reclr");
    drive(1'b0, 2'd3, '0, 1'b0);
    cyc("c5.b3"); cyc("c5.b4");
    chk("c5.busy_drop", {31'd0, bus.busy}, 32'd0);
    cyc("c5.rd3");
    chk("c5.word3", {16'd0, bus.out}, 32'd0);

    // 6. async reset mid-clear
    drive(1'b1, 2'd0, 16'hC0DE, 1'b0); cyc("pre6");
    drive(1'b0, 2'd0, '0, 1'b0); cyc("pre6.rd");
    drive(1'b0, 2'd0, '0, 1'b1); cyc("c6.start");
    drive(1'b0, 2'd0, '0, 1'b0); cyc("c6.b1");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("c6.async_busy", {31'd0, bus.busy}, 32'd0);
    chk("c6.async_out",  {16'd0, bus.out}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    drive(1'b1, 2'd1, 16'h1234, 1'b0); cyc("c6.wr");
    drive(1'b0, 2'd1, '0, 1'b0); cyc("c6.rd");
    chk("c6.accepted", {16'd0, bus.out}, 32'h1234);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
            1'($urandom_range(0, 15) == 0));
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
